// File: rtl/date_pkg.sv
// Shared widths, calendar constants and scheduler state encoding for the
// 30-day-month date adder and its two-client scheduler.
package date_pkg;
  localparam int DAYS_PER_MONTH = 30;
  localparam int DAY_W          = 5;
  localparam int N_W            = 6;
  localparam int CARRY_W        = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/date_add.sv
// Combinational 30-day-month adder: wraps (day-1)+n into a 1..30 day and a
// month-carry count; start days 0 and 31 are flagged as errors.
module date_add
  import date_pkg::*;
(
  input  logic [DAY_W-1:0]   i_day,
  input  logic [N_W-1:0]     i_n,
  output logic [DAY_W-1:0]   o_day,
  output logic [CARRY_W-1:0] o_carry,
  output logic               o_err
);

  // s never exceeds 92, so three thresholds replace a divider.
  function automatic logic [CARRY_W-1:0] months_of(input logic [6:0] s);
    if (s >= 7'(3 * DAYS_PER_MONTH))      return 2'd3;
    else if (s >= 7'(2 * DAYS_PER_MONTH)) return 2'd2;
    else if (s >= 7'(DAYS_PER_MONTH))     return 2'd1;
    else                                  return 2'd0;
  endfunction

  function automatic logic [DAY_W-1:0] wrap_day(input logic [6:0] s,
                                                input logic [CARRY_W-1:0] c);
    logic [6:0] rem;
    rem = s - 7'(c) * 7'(DAYS_PER_MONTH);
    return DAY_W'(rem + 7'd1);
  endfunction

  logic [6:0]         w_s;
  logic [CARRY_W-1:0] w_carry;
  logic               w_bad;

  assign w_s     = {2'b00, i_day} - 7'd1 + {1'b0, i_n};
  assign w_carry = months_of(w_s);
  assign w_bad   = (i_day == '0) || (i_day == DAY_W'(31));

  assign o_err   = w_bad;
  assign o_day   = w_bad ? '0 : wrap_day(w_s, w_carry);
  assign o_carry = w_bad ? '0 : w_carry;

endmodule

// File: rtl/date_adv_sched.sv
// Round-robin scheduler sharing one date_add between two requesters, with a
// single backpressured response channel tagged by requester id.
module date_adv_sched
  import date_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DAY_W-1:0]   req0_day,
  input  logic [N_W-1:0]     req0_n,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DAY_W-1:0]   req1_day,
  input  logic [N_W-1:0]     req1_n,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAY_W-1:0]   rsp_day,
  output logic [CARRY_W-1:0] rsp_carry,
  output logic               rsp_id,
  output logic               rsp_err,
  output logic               busy
);

  state_t             r_state;
  logic               r_last_id;
  logic [DAY_W-1:0]   r_day;
  logic [N_W-1:0]     r_n;
  logic               r_id;
  logic [DAY_W-1:0]   r_rsp_day;
  logic [CARRY_W-1:0] r_rsp_carry;
  logic               r_rsp_id;
  logic               r_rsp_err;

  logic               w_gnt_id;
  logic               w_accept;
  logic               w_hs;
  logic [DAY_W-1:0]   w_day_out;
  logic [CARRY_W-1:0] w_carry_out;
  logic               w_err_out;

  // On a tie the requester that was not served last wins.
  assign w_gnt_id   = (req0_valid && req1_valid) ? ~r_last_id : req1_valid;
  assign w_accept   = (r_state == IDLE) && !rst;
  assign req0_ready = w_accept && req0_valid && !w_gnt_id;
  assign req1_ready = w_accept && req1_valid &&  w_gnt_id;
  assign w_hs       = req0_ready || req1_ready;

  date_add u_add (
    .i_day   (r_day),
    .i_n     (r_n),
    .o_day   (w_day_out),
    .o_carry (w_carry_out),
    .o_err   (w_err_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_id   <= 1'b1;
      r_rsp_day   <= '0;
      r_rsp_carry <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_last_id <= w_gnt_id;
          r_state   <= CALC;
        end
        CALC: begin
          r_rsp_day   <= w_day_out;
          r_rsp_carry <= w_carry_out;
          r_rsp_err   <= w_err_out;
          r_rsp_id    <= r_id;
          r_state     <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand latches are pure data and only load on a request handshake.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_day <= w_gnt_id ? req1_day : req0_day;
      r_n   <= w_gnt_id ? req1_n   : req0_n;
      r_id  <= w_gnt_id;
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_day   = r_rsp_day;
  assign rsp_carry = r_rsp_carry;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;

endmodule
